// File: rtl/conv_pkg.sv
// Shared types and helpers for the parametrised 1-D convolution engine:
// FSM state encoding, counter/index width helpers and the signed clamp.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_MAC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Width of the intermediate used by sat(); covers 2T-bit products for T <= 32.
  localparam int unsigned SAT_W = 64;

  // Bits needed to index n entries (at least 1).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to count 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Clamp a signed value to the two's-complement range of 'width' bits.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] value,
                                                  input int unsigned width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(64'sd1) <<< (width - 1)) - SAT_W'(64'sd1);
    lo = -hi - SAT_W'(64'sd1);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One MAC lane: registered saturated product feeding a saturating accumulator.
// acc_nxt_c_o exposes the accumulator's next value so the final tap can be
// captured into the output register on the same edge it is accumulated.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int unsigned T = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [T-1:0] a_i,
  input  logic [T-1:0] b_i,
  output logic [T-1:0] acc_o,
  output logic [T-1:0] acc_nxt_c_o
);

  logic signed [2*T-1:0] prod_full_c;
  logic signed [T:0]     sum_c;
  logic [T-1:0]          prod_d, prod_q;
  logic [T-1:0]          acc_d, acc_q;
  logic                  pvld_q;

  always_comb begin
    prod_full_c = (2*T)'(signed'(a_i)) * (2*T)'(signed'(b_i));
    prod_d      = T'(sat(SAT_W'(prod_full_c), T));
    sum_c       = (T+1)'(signed'(acc_q)) + (T+1)'(signed'(prod_q));
    acc_d       = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (pvld_q) begin
      acc_d = T'(sat(SAT_W'(sum_c), T));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      pvld_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      pvld_q <= en_i;
      acc_q  <= acc_d;
    end
  end

  assign acc_o       = acc_q;
  assign acc_nxt_c_o = acc_d;

endmodule

// File: rtl/conv1d_par_stream.sv
// Streaming 1-D convolution: loads N samples and M runtime coefficients, then
// computes N-M+1 outputs in groups of P parallel lanes and streams them out.
module conv1d_par_stream
  import conv_pkg::*;
#(
  parameter int unsigned T    = 16,
  parameter int unsigned N    = 16,
  parameter int unsigned M    = 8,
  parameter int unsigned P    = 3,
  parameter int unsigned RELU = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [T-1:0] f_data,
  input  logic         f_valid,
  output logic         f_ready,
  output logic [T-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready
);

  localparam int unsigned NO     = N - M + 1;
  localparam int unsigned XCW    = cnt_w(N);
  localparam int unsigned FCW    = cnt_w(M);
  localparam int unsigned XIW    = idx_w(N);
  localparam int unsigned FIW    = idx_w(M);
  localparam int unsigned LW     = idx_w(P);
  localparam int unsigned LAST_G = NO - P;

  if (T < 4 || M < 2 || M > N || (NO % P) != 0) begin : g_bad_cfg
    $error("conv1d_par_stream: illegal T/N/M/P combination");
  end

  state_e         state_d, state_q;
  logic [XCW-1:0] x_cnt_d, x_cnt_q;
  logic [FCW-1:0] f_cnt_d, f_cnt_q;
  logic [FIW-1:0] tap_d, tap_q;
  logic [XIW-1:0] grp_d, grp_q;
  logic [LW-1:0]  lane_d, lane_q;
  logic           drain_d, drain_q;
  logic           x_ready_d, x_ready_q;
  logic           f_ready_d, f_ready_q;
  logic           y_valid_d, y_valid_q;
  logic [T-1:0]   y_d, y_q;
  logic           rd_vld_d, rd_vld_q;
  logic           x_fire_c, f_fire_c, y_fire_c, acc_clr_c;
  logic [T-1:0]   acc_sel_c;

  logic [T-1:0]   xmem_q [N];
  logic [T-1:0]   fmem_q [M];
  logic [T-1:0]   xrd_q  [P];
  logic [T-1:0]   frd_q;
  logic [XIW-1:0] xaddr_c [P];
  logic [T-1:0]   acc_c [P];
  logic [T-1:0]   acc_nxt_c [P];

  function automatic logic [T-1:0] relu_f(input logic [T-1:0] v);
    if ((RELU != 0) && v[T-1]) return '0;
    return v;
  endfunction

  // Lane j of group g at tap k reads x[gP + j + k].
  always_comb begin
    for (int j = 0; j < P; j++) begin
      xaddr_c[j] = grp_q + XIW'(j) + XIW'(tap_q);
    end
  end

  always_ff @(posedge clk) begin
    if (x_fire_c) xmem_q[XIW'(x_cnt_q)] <= x_data;
    if (f_fire_c) fmem_q[tap_q == tap_q ? FIW'(f_cnt_q) : FIW'(f_cnt_q)] <= f_data;
    for (int j = 0; j < P; j++) begin
      xrd_q[j] <= xmem_q[xaddr_c[j]];
    end
    frd_q <= fmem_q[tap_q];
  end

  for (genvar j = 0; j < P; j++) begin : g_lane
    conv_mac_lane #(.T(T)) u_lane (
      .clk         (clk),
      .reset       (reset),
      .clr_i       (acc_clr_c),
      .en_i        (rd_vld_q),
      .a_i         (xrd_q[j]),
      .b_i         (frd_q),
      .acc_o       (acc_c[j]),
      .acc_nxt_c_o (acc_nxt_c[j])
    );
  end

  always_comb begin
    state_d   = state_q;
    x_cnt_d   = x_cnt_q;
    f_cnt_d   = f_cnt_q;
    tap_d     = tap_q;
    grp_d     = grp_q;
    lane_d    = lane_q;
    drain_d   = drain_q;
    y_valid_d = y_valid_q;
    y_d       = y_q;
    rd_vld_d  = 1'b0;
    acc_clr_c = 1'b0;
    x_fire_c  = x_valid & x_ready_q;
    f_fire_c  = f_valid & f_ready_q;
    y_fire_c  = y_valid_q & y_ready;

    acc_sel_c = acc_c[0];
    for (int j = 0; j < P; j++) begin
      if (LW'(j) == lane_q + LW'(1)) acc_sel_c = acc_c[j];
    end

    case (state_q)
      ST_LOAD: begin
        if (x_fire_c) x_cnt_d = x_cnt_q + XCW'(1);
        if (f_fire_c) f_cnt_d = f_cnt_q + FCW'(1);
        if (x_cnt_d == XCW'(N) && f_cnt_d == FCW'(M)) begin
          state_d   = ST_MAC;
          tap_d     = '0;
          acc_clr_c = 1'b1;
        end
      end
      ST_MAC: begin
        rd_vld_d = 1'b1;
        tap_d    = tap_q + FIW'(1);
        if (tap_q == FIW'(M - 1)) begin
          tap_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        // Last product is accumulated on this edge, so capture the next value.
        if (drain_q) begin
          drain_d   = 1'b0;
          state_d   = ST_OUT;
          lane_d    = '0;
          y_valid_d = 1'b1;
          y_d       = relu_f(acc_nxt_c[0]);
        end
      end
      ST_OUT: begin
        if (y_fire_c) begin
          if (lane_q == LW'(P - 1)) begin
            y_valid_d = 1'b0;
            lane_d    = '0;
            acc_clr_c = 1'b1;
            if (grp_q == XIW'(LAST_G)) begin
              state_d = ST_LOAD;
              grp_d   = '0;
              x_cnt_d = '0;
              f_cnt_d = '0;
            end else begin
              state_d = ST_MAC;
              grp_d   = grp_q + XIW'(P);
            end
          end else begin
            lane_d = lane_q + LW'(1);
            y_d    = relu_f(acc_sel_c);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    x_ready_d = (state_d == ST_LOAD) && (x_cnt_d != XCW'(N));
    f_ready_d = (state_d == ST_LOAD) && (f_cnt_d != FCW'(M));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      x_cnt_q   <= '0;
      f_cnt_q   <= '0;
      tap_q     <= '0;
      grp_q     <= '0;
      lane_q    <= '0;
      drain_q   <= 1'b0;
      x_ready_q <= 1'b0;
      f_ready_q <= 1'b0;
      y_valid_q <= 1'b0;
      y_q       <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_cnt_q   <= x_cnt_d;
      f_cnt_q   <= f_cnt_d;
      tap_q     <= tap_d;
      grp_q     <= grp_d;
      lane_q    <= lane_d;
      drain_q   <= drain_d;
      x_ready_q <= x_ready_d;
      f_ready_q <= f_ready_d;
      y_valid_q <= y_valid_d;
      y_q       <= y_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign x_ready = x_ready_q;
  assign f_ready = f_ready_q;
  assign y_valid = y_valid_q;
  assign y_data  = y_q;

endmodule

// File: tb/tb_conv1d_par_stream.sv
// Directed bench for conv1d_par_stream: two instances (ReLU on/off) share the
// stimulus; results are compared against hand-computed vectors.
module tb_conv1d_par_stream;

  localparam int unsigned T  = 16;
  localparam int unsigned N  = 16;
  localparam int unsigned M  = 8;
  localparam int unsigned P  = 3;
  localparam int unsigned NO = N - M + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [T-1:0] x_data, f_data;
  logic         x_valid, f_valid, y_ready;
  logic         x_ready, f_ready, y_valid;
  logic [T-1:0] y_data;
  logic         x_ready_nr, f_ready_nr, y_valid_nr;
  logic [T-1:0] y_data_nr;

  logic [T-1:0] xv [N];
  logic [T-1:0] fv [M];
  logic [T-1:0] ev [NO];
  logic [T-1:0] ev_nr [NO];

  int cyc = 0;
  int last_hs = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv1d_par_stream #(.T(T), .N(N), .M(M), .P(P), .RELU(1)) dut (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  conv1d_par_stream #(.T(T), .N(N), .M(M), .P(P), .RELU(0)) dut_nr (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready_nr),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready_nr),
    .y_data(y_data_nr), .y_valid(y_valid_nr), .y_ready(y_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 0: always, 1: random, 2: wait for other stream done then random,
  // 3: start so both streams finish on the same cycle.
  function automatic bit gate(input int mode, input int other_idx, input int other_len,
                              input int self_len);
    case (mode)
      1:       return 1'($urandom_range(0, 1));
      2:       return (other_idx >= other_len) && 1'($urandom_range(0, 1));
      3:       return other_idx >= (other_len - self_len);
      default: return 1'b1;
    endcase
  endfunction

  task automatic load_job(input int xmode, input int fmode);
    int xi = 0;
    int fi = 0;
    int budget = 0;
    bit xf, ff;
    while ((xi < N || fi < M) && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (xi == N) check("x_ready_full", 32'(x_ready), 32'd0);
      if (fi == M) check("f_ready_full", 32'(f_ready), 32'd0);
      // Past their counts both streams keep offering junk that must be refused.
      x_valid = (xi < N) ? gate(xmode, fi, M, N) : 1'b1;
      x_data  = (xi < N) ? xv[xi] : 16'h7777;
      f_valid = (fi < M) ? gate(fmode, xi, N, M) : 1'b1;
      f_data  = (fi < M) ? fv[fi] : 16'h7777;
      xf = x_valid && x_ready && (xi < N);
      ff = f_valid && f_ready && (fi < M);
      if (xf || ff) last_hs = cyc;
      @(posedge clk);
      if (xf) xi++;
      if (ff) fi++;
    end
    check("load_done", 32'(xi == N && fi == M), 32'd1);
  endtask

  task automatic collect(input int nexp, input int stall_idx, input bit chk_nr);
    int idx = 0;
    int budget = 0;
    int stall = 0;
    bit first = 1'b1;
    while (idx < nexp && budget < 2000) begin
      @(negedge clk);
      budget++;
      x_valid = 1'b0;
      f_valid = 1'b0;
      if (y_valid && first) begin
        check("first_latency", 32'(cyc - last_hs), 32'(M + 3));
        first = 1'b0;
      end
      if (idx == stall_idx && y_valid && stall < 5) begin
        y_ready = 1'b0;
        stall++;
        check("stall_hold", {15'd0, y_valid, y_data}, {15'd0, 1'b1, ev[idx]});
      end else begin
        y_ready = 1'b1;
      end
      if (y_valid && y_ready) begin
        check($sformatf("y%0d", idx), 32'(y_data), 32'(ev[idx]));
        if (chk_nr) check($sformatf("y_norelu%0d", idx), 32'(y_data_nr), 32'(ev_nr[idx]));
        idx++;
      end
    end
    check("collect_done", 32'(idx), 32'(nexp));
  endtask

  task automatic set_unit();
    for (int n = 0; n < N; n++) xv[n] = 16'd1;
    for (int k = 0; k < M; k++) fv[k] = 16'd1;
    for (int i = 0; i < NO; i++) ev[i] = 16'd8;
  endtask

  task automatic set_ramp();
    for (int n = 0; n < N; n++) xv[n] = 16'(n);
    for (int k = 0; k < M; k++) fv[k] = 16'd0;
    fv[0]     = 16'd1;
    fv[M - 1] = 16'd2;
    for (int i = 0; i < NO; i++) ev[i] = 16'(3 * i + 14);
  endtask

  initial begin
    reset   = 1'b1;
    x_valid = 1'b0;
    f_valid = 1'b0;
    x_data  = '0;
    f_data  = '0;
    y_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x_ready", 32'(x_ready), 32'd0);
    check("rst_f_ready", 32'(f_ready), 32'd0);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_y_data", 32'(y_data), 32'd0);
    check("rst_nr", {30'd0, x_ready_nr, y_valid_nr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_x_ready", 32'(x_ready), 32'd1);
    check("post_rst_f_ready", 32'(f_ready), 32'd1);
    check("post_rst_f_ready_nr", 32'(f_ready_nr), 32'd1);

    set_unit();
    load_job(0, 2);
    collect(NO, -1, 1'b0);

    set_ramp();
    load_job(0, 0);
    collect(NO, 4, 1'b0);

    set_ramp();
    load_job(2, 1);
    collect(NO, -1, 1'b0);

    for (int n = 0; n < N; n++) xv[n] = 16'h7FFF;
    for (int k = 0; k < M; k++) fv[k] = 16'd2;
    for (int i = 0; i < NO; i++) ev[i] = 16'h7FFF;
    load_job(0, 3);
    collect(NO, -1, 1'b0);

    for (int n = 0; n < N; n++) xv[n] = 16'd1;
    for (int k = 0; k < M; k++) fv[k] = 16'hFFFF;
    for (int i = 0; i < NO; i++) begin
      ev[i]    = 16'd0;
      ev_nr[i] = 16'hFFF8;
    end
    load_job(1, 1);
    collect(NO, -1, 1'b1);

    // Abort a job while group 1 is computing, then rerun a full job.
    set_unit();
    load_job(0, 0);
    collect(P, -1, 1'b0);
    @(negedge clk);
    y_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_y_valid", 32'(y_valid), 32'd0);
    check("mid_rst_x_ready", 32'(x_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_back", {30'd0, x_ready, f_ready}, 32'd3);
    load_job(0, 0);
    collect(NO, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
